// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared state encoding and width default for the perf counter bank
package perf_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

endpackage

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one saturating or wrapping counter with sticky overflow flag
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      zero the count and the overflow flag (wins over inc)
//   inc        add one this cycle
//   value      current count
//   ovf        set when an increment arrives while value is all-ones
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&value) begin
                ovf <= 1'b1;
                // Saturating counters simply hold all-ones.
                if (SATURATE == 0) begin
                    value <= '0;
                end
            end else begin
                value <= value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters plus a cycle counter with run control
//
// Optional feature macro: PERF_SNAPSHOT_EN (shadow copies; rd_data reads the shadows).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_pulse  clear every counter and ovf, enter RUN (beats done)
//   done         leave RUN for FROZEN; the cycle it is sampled is not counted
//   evt          per-event increment strobes
//   snap_req     copy every live counter into its shadow (snapshot build only)
//   rd_sel       counter select; NUM_EVT is the cycle counter, above that reads 0
//   rd_data      registered read data, valid one cycle after rd_sel
//   ovf          sticky overflow flags, bit NUM_EVT is the cycle counter
//   running      high while in RUN
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int SATURATE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_pulse,
    input  logic                         done,
    input  logic [NUM_EVT-1:0]           evt,
    input  logic                         snap_req,
    input  logic [$clog2(NUM_EVT+1)-1:0] rd_sel,
    output logic [CNT_W-1:0]             rd_data,
    output logic [NUM_EVT:0]             ovf,
    output logic                         running
);

    localparam int SEL_W = $clog2(NUM_EVT + 1);
    localparam logic [SEL_W:0] LAST_SEL = (SEL_W + 1)'(NUM_EVT);

    perf_state_e state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_pulse) begin
            state_nxt = RUN;
        end else if ((state == RUN) && done) begin
            state_nxt = FROZEN;
        end
    end

    assign running = (state == RUN);

    // The done cycle itself is excluded; start_pulse needs no gating here
    // because clear takes priority inside each cell.
    logic             counting;
    logic [NUM_EVT:0] inc_vec;

    assign counting = running & ~done;
    assign inc_vec  = {counting, {NUM_EVT{counting}} & evt};

    logic [CNT_W-1:0] live [NUM_EVT+1];

    for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (start_pulse),
            .inc   (inc_vec[gi]),
            .value (live[gi]),
            .ovf   (ovf[gi])
        );
    end

    logic [CNT_W-1:0] src [NUM_EVT+1];

`ifdef PERF_SNAPSHOT_EN
    // Shadows sample the registered live values, so a coincident increment
    // or clear is not yet visible: the pre-update value is captured.
    logic [CNT_W-1:0] shadow [NUM_EVT+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap_req) begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                shadow[i] <= live[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i <= NUM_EVT; i++) begin
            src[i] = shadow[i];
        end
    end
`else
    logic unused_snap_req;
    assign unused_snap_req = snap_req;

    always_comb begin
        for (int i = 0; i <= NUM_EVT; i++) begin
            src[i] = live[i];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_sel} > LAST_SEL) begin
            rd_data <= '0;
        end else begin
            rd_data <= src[rd_sel];
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed and random checks of perf_counter_bank against a count model
module tb_perf_counter_bank;

    localparam int NE   = 4;
    localparam int CW   = 8;
    localparam int SW   = $clog2(NE + 1);
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_pulse;
    logic          done;
    logic          snap_req;
    logic [NE-1:0] evt;
    logic [SW-1:0] rd_sel;
    logic [CW-1:0] rd_data_s, rd_data_w;
    logic [NE:0]   ovf_s, ovf_w;
    logic          running_s, running_w;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(1)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .start_pulse (start_pulse),
        .done        (done),
        .evt         (evt),
        .snap_req    (snap_req),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data_s),
        .ovf         (ovf_s),
        .running     (running_s)
    );

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(0)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .start_pulse (start_pulse),
        .done        (done),
        .evt         (evt),
        .snap_req    (snap_req),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data_w),
        .ovf         (ovf_w),
        .running     (running_w)
    );

    int checks = 0;
    int errors = 0;

    // Model: true number of increments since the last clear; the visible
    // value is derived from it by clamping or modulo.
    int            cnt [NE+1];
    int            shadow_s [NE+1];
    int            shadow_w [NE+1];
    bit            m_run;
    logic [CW-1:0] exp_rd_s, exp_rd_w;

    function automatic int sat_view(input int n);
        return (n > MAXV) ? MAXV : n;
    endfunction

    function automatic int wrap_view(input int n);
        return n % (MAXV + 1);
    endfunction

    function automatic logic [NE:0] exp_ovf();
        logic [NE:0] v;
        for (int i = 0; i <= NE; i++) v[i] = (cnt[i] > MAXV);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= NE; i++) begin
            cnt[i]      = 0;
            shadow_s[i] = 0;
            shadow_w[i] = 0;
        end
        m_run    = 1'b0;
        exp_rd_s = '0;
        exp_rd_w = '0;
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        if (int'(rd_sel) > NE) begin
            exp_rd_s = '0;
            exp_rd_w = '0;
        end else begin
`ifdef PERF_SNAPSHOT_EN
            exp_rd_s = CW'(shadow_s[rd_sel]);
            exp_rd_w = CW'(shadow_w[rd_sel]);
`else
            exp_rd_s = CW'(sat_view(cnt[rd_sel]));
            exp_rd_w = CW'(wrap_view(cnt[rd_sel]));
`endif
        end
        if (snap_req) begin
            for (int i = 0; i <= NE; i++) begin
                shadow_s[i] = sat_view(cnt[i]);
                shadow_w[i] = wrap_view(cnt[i]);
            end
        end
        if (start_pulse) begin
            for (int i = 0; i <= NE; i++) cnt[i] = 0;
            m_run = 1'b1;
        end else if (m_run) begin
            if (done) begin
                m_run = 1'b0;
            end else begin
                cnt[NE]++;
                for (int i = 0; i < NE; i++) if (evt[i]) cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        chk("rd_data_sat",  rd_data_s, exp_rd_s);
        chk("rd_data_wrap", rd_data_w, exp_rd_w);
        chk("running_sat",  running_s, m_run);
        chk("running_wrap", running_w, m_run);
        chk("ovf_sat",      ovf_s,     exp_ovf());
        chk("ovf_wrap",     ovf_w,     exp_ovf());
    endtask

    task automatic step(input bit st, input bit dn, input logic [NE-1:0] ev,
                        input bit sn, input logic [SW-1:0] sel);
        start_pulse = st;
        done        = dn;
        evt         = ev;
        snap_req    = sn;
        rd_sel      = sel;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Counters must be static (IDLE/FROZEN): snapshot first so both builds read the same value.
    task automatic read_chk(input string tag, input logic [SW-1:0] sel,
                            input int exp_s, input int exp_w);
        step(1'b0, 1'b0, '0, 1'b1, sel);
        step(1'b0, 1'b0, '0, 1'b0, sel);
        chk({tag, "_sat"},  rd_data_s, 64'(exp_s));
        chk({tag, "_wrap"}, rd_data_w, 64'(exp_w));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start_pulse = 1'b0;
        done        = 1'b0;
        evt         = '0;
        snap_req    = 1'b0;
        rd_sel      = '0;
        #1;
        model_reset();
        chk("rst_rd_sat",   rd_data_s, 0);
        chk("rst_ovf_sat",  ovf_s,     0);
        chk("rst_run_sat",  running_s, 0);
        chk("rst_rd_wrap",  rd_data_w, 0);
        chk("rst_ovf_wrap", ovf_w,     0);
        chk("rst_run_wrap", running_w, 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // No counting without a start_pulse after reset.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'hF, 1'b0, SW'(i));
        read_chk("idle_cyc", SW'(NE), 0, 0);

        // Basic run: 20 RUN cycles, evt[0] in the first 10.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, (i < 10) ? 4'b0001 : 4'b0000, 1'b0, SW'($urandom_range(0, 7)));
        step(1'b0, 1'b1, 4'hF, 1'b0, '0);
        chk("basic_running", running_s, 0);
        read_chk("basic_cyc", SW'(NE), 20, 20);
        read_chk("basic_evt0", 3'd0, 10, 10);
        read_chk("sel_out_of_range", 3'd6, 0, 0);

        // 258 increments: saturating holds 255, wrapping reads 2.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 258; i++) step(1'b0, 1'b0, 4'b0010, 1'b0, 3'd1);
        step(1'b0, 1'b1, '0, 1'b0, '0);
        read_chk("ovf258_evt1", 3'd1, 255, 2);
        chk("ovf258_flag_sat",  ovf_s[1], 1);
        chk("ovf258_flag_wrap", ovf_w[1], 1);

        // 300 increments on the saturating bank.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        chk("clear_ovf", ovf_s, 0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 4'b0010, 1'b0, 3'd1);
        step(1'b0, 1'b1, '0, 1'b0, '0);
        read_chk("sat300_evt1", 3'd1, 255, 300 % 256);
        chk("sat300_flag", ovf_s[1], 1);

        // start_pulse and done together: start wins.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'hF, 1'b0, '0);
        step(1'b1, 1'b1, 4'hF, 1'b0, '0);
        chk("prio_running", running_s, 1);
        step(1'b0, 1'b1, 4'hF, 1'b0, '0);
        read_chk("prio_cyc", SW'(NE), 0, 0);
        read_chk("prio_evt0", 3'd0, 0, 0);

        // Snapshot at live count 5, then three more increments.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0100, 1'b0, 3'd2);
        step(1'b0, 1'b0, 4'b0100, 1'b1, 3'd2);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 3'd2);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 3'd2);
`ifdef PERF_SNAPSHOT_EN
        chk("snap_evt2", rd_data_s, 5);
`else
        chk("snap_evt2", rd_data_s, 7);
`endif
        step(1'b0, 1'b1, '0, 1'b0, '0);

        // Reset after 7 RUN cycles.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'($urandom), 1'b0, SW'(NE));
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'hF, 1'b0, SW'(NE));
        chk("post_rst_running", running_s, 0);
        read_chk("post_rst_cyc", SW'(NE), 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                     4'($urandom), $urandom_range(0, 7) == 0, SW'($urandom_range(0, 7)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
